muldiv_sequencer: RTL

//  Multicycle controller for the CPU's MULT/DIV/DIVM resource (mult unit, div unit, Hi/Lo registers).

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/muldiv_sequencer_if.sv | 35 +++
 rtl/md_down_counter.sv | 28 ++
 rtl/muldiv_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the MULT/DIV/DIVM sequencer: op codes, state encodings
// and the bundle of select/enable lines the sequencer drives.
package cpu_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULT = 2'd0,
        MD_OP_DIV  = 2'd1,
        MD_OP_DIVM = 2'd2,
        MD_OP_RSVD = 2'd3
    } md_op_e;

    typedef enum logic [3:0] {
        MD_ST_IDLE  = 4'd0,
        MD_ST_M_GO  = 4'd1,
        MD_ST_D_LD  = 4'd2,
        MD_ST_FA    = 4'd3,
        MD_ST_LA    = 4'd4,
        MD_ST_FB    = 4'd5,
        MD_ST_LB    = 4'd6,
        MD_ST_D_CHK = 4'd7,
        MD_ST_RUN   = 4'd8,
        MD_ST_WB    = 4'd9,
        MD_ST_ERR   = 4'd10
    } md_state_e;

    typedef struct packed {
        logic mem_req;
        logic mem_sel;
        logic mult_ctrl;
        logic reg_a_write;
        logic reg_b_write;
        logic div_a_sel;
        logic div_b_sel;
        logic md_sel;
        logic hi_ctrl;
        logic lo_ctrl;
        logic busy;
        logic done;
        logic div0_excpt;
    } md_ctrl_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Handshake between ctrl_unit and the mult/div sequencer; the sequencer is the slave side.
interface muldiv_sequencer_if;

    logic       start;
    logic [1:0] op;
    logic       mem_ack;
    logic       div_zero;

    logic       mem_req;
    logic       mem_sel;
    logic       mult_ctrl;
    logic       RegAWrite;
    logic       RegBWrite;
    logic       DIVASelect;
    logic       DIVBSelect;
    logic       MDSelect;
    logic       HiCtrl;
    logic       LoCtrl;
    logic       busy;
    logic       done;
    logic       div0_excpt;

    modport slave (
        input  start, op, mem_ack, div_zero,
        output mem_req, mem_sel, mult_ctrl, RegAWrite, RegBWrite, DIVASelect, DIVBSelect,
               MDSelect, HiCtrl, LoCtrl, busy, done, div0_excpt
    );

    modport master (
        output start, op, mem_ack, div_zero,
        input  mem_req, mem_sel, mult_ctrl, RegAWrite, RegBWrite, DIVASelect, DIVBSelect,
               MDSelect, HiCtrl, LoCtrl, busy, done, div0_excpt
    );

endinterface

// File: rtl/md_down_counter.sv
// Loadable down counter that saturates at zero; times the fixed mult/div execution latency.
module md_down_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle controller for the MULT/DIV/DIVM resource: operand load, DIVM fetches,
// fixed-latency execution, divide-by-zero check and Hi/Lo write-back.
module muldiv_sequencer
    import cpu_pkg::*;
#(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic                clk,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        r_state;
    md_state_e        w_next;
    logic             r_kind_mult;
    logic             w_accept;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_cnt_zero;
    md_ctrl_t         w_ctrl;

    assign w_accept = (r_state == MD_ST_IDLE) && bus.start && (md_op_e'(bus.op) != MD_OP_RSVD);

    md_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= MD_ST_IDLE;
            r_kind_mult <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_kind_mult <= (md_op_e'(bus.op) == MD_OP_MULT);
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        case (r_state)
            MD_ST_IDLE: begin
                if (bus.start) begin
                    case (md_op_e'(bus.op))
                        MD_OP_MULT: w_next = MD_ST_M_GO;
                        MD_OP_DIV:  w_next = MD_ST_D_LD;
                        MD_OP_DIVM: w_next = MD_ST_FA;
                        default:    w_next = MD_ST_IDLE;
                    endcase
                end
            end
            MD_ST_M_GO: begin
                w_load     = 1'b1;
                w_load_val = MULT_LOAD;
                w_next     = MD_ST_RUN;
            end
            MD_ST_D_LD: w_next = MD_ST_D_CHK;
            MD_ST_FA:   if (bus.mem_ack) w_next = MD_ST_LA;
            MD_ST_LA:   w_next = MD_ST_FB;
            MD_ST_FB:   if (bus.mem_ack) w_next = MD_ST_LB;
            MD_ST_LB:   w_next = MD_ST_D_CHK;
            MD_ST_D_CHK: begin
                if (bus.div_zero) begin
                    w_next = MD_ST_ERR;
                end else begin
                    w_load     = 1'b1;
                    w_load_val = DIV_LOAD;
                    w_next     = MD_ST_RUN;
                end
            end
            MD_ST_RUN: begin
                if (w_cnt_zero) w_next = MD_ST_WB;
                else            w_dec  = 1'b1;
            end
            MD_ST_WB:   w_next = MD_ST_IDLE;
            MD_ST_ERR:  w_next = MD_ST_IDLE;
            default:    w_next = MD_ST_IDLE;
        endcase
    end

    // Moore decode: outputs depend on the state register (and the kind latch in WB) only.
    always_comb begin
        w_ctrl      = '0;
        w_ctrl.busy = (r_state != MD_ST_IDLE);
        case (r_state)
            MD_ST_M_GO: w_ctrl.mult_ctrl = 1'b1;
            MD_ST_D_LD: begin
                w_ctrl.reg_a_write = 1'b1;
                w_ctrl.reg_b_write = 1'b1;
            end
            MD_ST_FA:   w_ctrl.mem_req = 1'b1;
            MD_ST_LA: begin
                w_ctrl.reg_a_write = 1'b1;
                w_ctrl.div_a_sel   = 1'b1;
            end
            MD_ST_FB: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.mem_sel = 1'b1;
            end
            MD_ST_LB: begin
                w_ctrl.reg_b_write = 1'b1;
                w_ctrl.div_b_sel   = 1'b1;
            end
            MD_ST_WB: begin
                w_ctrl.hi_ctrl = 1'b1;
                w_ctrl.lo_ctrl = 1'b1;
                w_ctrl.md_sel  = r_kind_mult;
                w_ctrl.done    = 1'b1;
            end
            MD_ST_ERR:  w_ctrl.div0_excpt = 1'b1;
            default:    ;
        endcase
    end

    assign bus.mem_req    = w_ctrl.mem_req;
    assign bus.mem_sel    = w_ctrl.mem_sel;
    assign bus.mult_ctrl  = w_ctrl.mult_ctrl;
    assign bus.RegAWrite  = w_ctrl.reg_a_write;
    assign bus.RegBWrite  = w_ctrl.reg_b_write;
    assign bus.DIVASelect = w_ctrl.div_a_sel;
    assign bus.DIVBSelect = w_ctrl.div_b_sel;
    assign bus.MDSelect   = w_ctrl.md_sel;
    assign bus.HiCtrl     = w_ctrl.hi_ctrl;
    assign bus.LoCtrl     = w_ctrl.lo_ctrl;
    assign bus.busy       = w_ctrl.busy;
    assign bus.done       = w_ctrl.done;
    assign bus.div0_excpt = w_ctrl.div0_excpt;

endmodule
